// File: rtl/serial_tx_queue_if.sv
// Byte-in / serial-out bus for serial_tx_queue: enqueue side, serial strobe side and queue status.
interface serial_tx_queue_if #(
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [7:0]    data_in;
   logic          enqueue_in;
   logic          busy_in;
   logic          data_out;
   logic          write_out;
   logic          status_out;
   logic          empty_out;
   logic [CW-1:0] count_out;
   logic          busy_out;

   modport master (
      output data_in, enqueue_in, busy_in,
      input  data_out, write_out, status_out, empty_out, count_out, busy_out
   );

   modport slave (
      input  data_in, enqueue_in, busy_in,
      output data_out, write_out, status_out, empty_out, count_out, busy_out
   );
endinterface

// File: rtl/serial_tx_queue.sv
// Byte FIFO feeding an MSB-first serializer; each bit is a timed write_out strobe
// started only once the receiver reports not-busy.
module serial_tx_queue #(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned BIT_HIGH = 10,
   parameter int unsigned BIT_LOW  = 10
) (
   input logic            clock1M,
   input logic            reset,
   serial_tx_queue_if.slave bus
);
   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned CW   = $clog2(DEPTH + 1);
   localparam int unsigned TMAX = (BIT_HIGH > BIT_LOW) ? BIT_HIGH : BIT_LOW;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   typedef enum logic [1:0] {IDLE, WAIT_RDY, HIGH, LOW} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [2:0]    bit_cnt, bit_cnt_nxt;
   logic [7:0]    shift, shift_nxt;
   logic          data_r, data_nxt;
   logic          write_r, write_nxt;
   logic          busy_r;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_nxt;
   logic          full_r, empty_r;
   logic          enqueue_q;
   logic          push_c, pop_c;

   // One push per enqueue_in rising edge; a full queue only accepts it if it pops the same cycle.
   assign pop_c  = (state == IDLE) && (count != '0);
   assign push_c = bus.enqueue_in && !enqueue_q && ((count != CW'(DEPTH)) || pop_c);

   always_comb begin
      count_nxt = count;
      case ({push_c, pop_c})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clock1M or posedge reset) begin
      if (reset) begin
         enqueue_q <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         full_r    <= 1'b0;
         empty_r   <= 1'b1;
      end else begin
         enqueue_q <= bus.enqueue_in;
         if (push_c) wr_ptr <= wr_ptr + PW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
         count   <= count_nxt;
         full_r  <= (count_nxt == CW'(DEPTH));
         empty_r <= (count_nxt == '0);
      end
   end

   // Storage array carries no reset; pointers and occupancy define validity.
   always_ff @(posedge clock1M) begin
      if (push_c) mem[wr_ptr] <= bus.data_in;
   end

   always_ff @(posedge clock1M or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         timer   <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         data_r  <= 1'b0;
         write_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         bit_cnt <= bit_cnt_nxt;
         shift   <= shift_nxt;
         data_r  <= data_nxt;
         write_r <= write_nxt;
         busy_r  <= (state != IDLE);
      end
   end

   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift;
      data_nxt    = data_r;
      write_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (pop_c) begin
               shift_nxt   = mem[rd_ptr];
               bit_cnt_nxt = '0;
               state_nxt   = WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            if (!bus.busy_in) begin
               data_nxt  = shift[7];
               write_nxt = 1'b1;
               timer_nxt = '0;
               state_nxt = HIGH;
            end
         end
         HIGH: begin
            if (timer == TW'(BIT_HIGH - 1)) begin
               timer_nxt = '0;
               state_nxt = LOW;
            end else begin
               write_nxt = 1'b1;
               timer_nxt = timer + TW'(1);
            end
         end
         LOW: begin
            if (timer == TW'(BIT_LOW - 1)) begin
               timer_nxt = '0;
               if (bit_cnt == 3'd7) begin
                  state_nxt = IDLE;
               end else begin
                  shift_nxt   = {shift[6:0], 1'b0};
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  state_nxt   = WAIT_RDY;
               end
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.data_out   = data_r;
   assign bus.write_out  = write_r;
   assign bus.status_out = full_r;
   assign bus.empty_out  = empty_r;
   assign bus.count_out  = count;
   assign bus.busy_out   = busy_r;
endmodule

// File: doc/serial_tx_queue.md
# serial_tx_queue

Byte-to-serial transmitter that feeds the serial deserializer/byte-queue block (`top`) on the same 1 MHz domain. Parallel bytes are pushed into an internal FIFO by a pulse on `enqueue_in`. Each byte is popped and shifted out MSB-first as a `data_out` level qualified by a timed `write_out` strobe. Before each bit it waits for the receiver's `status_out`, connected here as `busy_in`, to be low.

## Interface

Parameters:
- `DEPTH`, 8: FIFO depth in bytes; power of two, ≥2.
- `BIT_HIGH`, 10: cycles `write_out` is held high per bit; ≥1.
- `BIT_LOW`, 10: cycles `write_out` is held low after each bit; ≥1.

Ports:
- `clock1M` in 1: system clock (1 MHz).
- `reset` in 1: asynchronous, active-high; clears all state.
- `data_in` in 8: byte to enqueue.
- `enqueue_in` in 1: push request; rising-edge detected.
- `busy_in` in 1: receiver busy; a new bit is not started while it is 1.
- `data_out` out 1: serial bit, MSB first.
- `write_out` out 1: bit strobe; `data_out` is stable for the whole high phase.
- `status_out` out 1: FIFO full.
- `empty_out` out 1: FIFO empty.
- `count_out` out $clog2(DEPTH+1): FIFO occupancy; excludes the byte in the shift register.
- `busy_out` out 1: transmitter is mid-byte (state ≠ IDLE).

## Operation

- **Reset values:** `data_out`=0, `write_out`=0, `status_out`=0, `empty_out`=1, `count_out`=0, `busy_out`=0.
  - FIFO pointers, shift register, bit counter and timer all clear; state = IDLE.
  - `enqueue_q` (registered `enqueue_in`) clears to 0.
- **Push**
  - Occurs on an edge where `enqueue_in`=1 and `enqueue_q`=0.
  - `data_in` is captured at that edge. One push per pulse, regardless of pulse length.
  - Push when full (`count_out`=DEPTH) is dropped silently; FIFO unchanged.
- **Pop**
  - Only in IDLE when not empty.
  - Head byte moves to an 8-bit shift register; bit counter = 0; state → WAIT_RDY.
- **Simultaneous push and pop** (including when full): both take effect; count unchanged.
  - Full-with-pop accepts the push.
  - Push into an empty FIFO is not bypassed; the pop happens the following cycle.
- **FSM**
  - IDLE: `write_out`=0. Pops as above if not empty.
  - WAIT_RDY: `write_out`=0. If `busy_in`=0, then next edge: `data_out`=shift[7], `write_out`=1, timer=0, → HIGH. Otherwise stay.
  - HIGH: `write_out`=1 for exactly BIT_HIGH cycles, then `write_out`=0, timer=0, → LOW.
  - LOW: `write_out`=0 for exactly BIT_LOW cycles. Then:
    - if bit counter = 7 → IDLE;
    - else shift left by 1, increment counter, → WAIT_RDY.
- **`busy_in` sampling:** only in WAIT_RDY. Changes during HIGH/LOW are ignored; no bit is aborted or repeated.
- **`data_out`** holds its value through LOW and IDLE until the next bit start. Wrong-phase values are don't-care but must not glitch during HIGH.
- **FIFO pointers:** log2(DEPTH) bits with natural wrap; full/empty derive from a separate occupancy counter.

## Timing

- **Push latency:** `count_out` and `empty_out` update on the push edge (registered outputs).
- **Start latency:** push into an empty idle block with `busy_in`=0 at edge E:
  - pop at E+1;
  - `write_out` rises at E+2.
- **Bit period** with `busy_in`=0: 1 + BIT_HIGH + BIT_LOW cycles (21 with defaults).
- **Byte time:** 8 × 21 = 168 cycles with defaults.
- **Back-to-back bytes:** the next byte's first `write_out` rises 2 cycles after the last LOW ends (IDLE pop, then WAIT_RDY).
- **`status_out`** asserts on the edge `count_out` reaches DEPTH and deasserts on the pop edge.
- **Reset mid-byte:** `write_out` drops asynchronously. The byte in flight and all queued bytes are discarded; no partial byte resumes.

## Test plan

1. **Reset:** assert reset 100 cycles, then release. All outputs hold reset values; no `write_out` activity for 500 cycles.
2. **Single byte:** push 8'hAA with `busy_in`=0.
   - `write_out` rises 2 cycles after the push edge.
   - 8 strobes, each exactly 10 high / 10 low.
   - `data_out` = 1,0,1,0,1,0,1,0.
   - `busy_out` falls 168 cycles after the first rise.
3. **Full and overflow:** hold `busy_in`=1 and push 8'h01..8'h0A.
   - After 8'h0A: `count_out`=8, `status_out`=1; 8'h01 is in the shift register and 8'h0A is dropped.
   - Release `busy_in`: bytes 01..09 are serialized in order.
4. **Backpressure:** push 8'hF0; raise `busy_in` during bit 3's HIGH phase for 50 cycles.
   - Bit 3 completes normally.
   - Bit 4 starts 1 cycle after `busy_in` falls.
   - Full stream = 1,1,1,1,0,0,0,0.
5. **Pulse width:** hold `enqueue_in` high 20 cycles with 8'h0F. Exactly one push; `count_out` peaks at 1; 8'h0F is sent once.
6. **Reset mid-byte:** with 3 bytes queued, assert reset during a HIGH phase.
   - `write_out`=0 immediately; `count_out`=0, `empty_out`=1.
   - After release, no strobes occur until a new push.
